// File: rtl/ex3_pkg.sv
// Shared definitions for the ex3 input-conditioning stage: debounce FSM
// state indices, one-hot state type and the default debounce depth.
package ex3_pkg;

  localparam int unsigned ST0  = 0;
  localparam int unsigned CHK1 = 1;
  localparam int unsigned ST1  = 2;
  localparam int unsigned CHK0 = 3;
  localparam int unsigned ST_W = 4;

  localparam int unsigned DEB_CYCLES_DEF = 4;

  typedef enum logic [ST_W-1:0] {
    S_ST0  = ST_W'(1) << ST0,
    S_CHK1 = ST_W'(1) << CHK1,
    S_ST1  = ST_W'(1) << ST1,
    S_CHK0 = ST_W'(1) << CHK0
  } deb_st_e;

endpackage

// File: rtl/ex3_deb_ch.sv
// One debounce channel: 2-flop synchroniser, one-hot debounce FSM with
// sample counter, registered level and 0->1 rise pulse.
module ex3_deb_ch
  import ex3_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_b,
  input  logic i_clr,
  input  logic i_raw,
  output logic o_lvl,
  output logic o_rise
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_s1;
  logic             r_s;
  deb_st_e          r_state;
  deb_st_e          w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_lvl;
  logic             w_lvl_nxt;
  logic             r_rise;
  logic             w_rise_nxt;

  // Synchroniser keeps sampling through clr so a held level is re-accepted.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_s1 <= 1'b0;
      r_s  <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s  <= r_s1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_state <= S_ST0;
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lvl   <= w_lvl_nxt;
      r_rise  <= w_rise_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lvl_nxt   = r_lvl;
    w_rise_nxt  = 1'b0;
    if (i_clr) begin
      w_state_nxt = S_ST0;
      w_cnt_nxt   = '0;
      w_lvl_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        S_ST0: begin
          if (r_s) begin
            w_state_nxt = S_CHK1;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_cnt_nxt   = '0;
          end
        end
        S_CHK1: begin
          if (!r_s) begin
            w_state_nxt = S_ST0;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_ST1;
            w_cnt_nxt   = '0;
            w_lvl_nxt   = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        S_ST1: begin
          if (!r_s) begin
            w_state_nxt = S_CHK0;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_cnt_nxt   = '0;
          end
        end
        S_CHK0: begin
          if (r_s) begin
            w_state_nxt = S_ST1;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_ST0;
            w_cnt_nxt   = '0;
            w_lvl_nxt   = 1'b0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_ST0;
          w_cnt_nxt   = '0;
          w_lvl_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign o_lvl  = r_lvl;
  assign o_rise = r_rise;

endmodule

// File: rtl/ex3_in_cond.sv
// Input conditioning for the ex3 FSM: three independent synchronise and
// debounce channels producing clean levels a/b/c and rise pulses.
module ex3_in_cond
  import ex3_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic raw_a,
  input  logic raw_b,
  input  logic raw_c,
  output logic a,
  output logic b,
  output logic c,
  output logic a_rise,
  output logic b_rise,
  output logic c_rise
);

  ex3_deb_ch #(.DEB_CYCLES(DEB_CYCLES)) u_ch_a (
    .i_clk   (clk),
    .i_rst_b (rst_b),
    .i_clr   (clr),
    .i_raw   (raw_a),
    .o_lvl   (a),
    .o_rise  (a_rise)
  );

  ex3_deb_ch #(.DEB_CYCLES(DEB_CYCLES)) u_ch_b (
    .i_clk   (clk),
    .i_rst_b (rst_b),
    .i_clr   (clr),
    .i_raw   (raw_b),
    .o_lvl   (b),
    .o_rise  (b_rise)
  );

  ex3_deb_ch #(.DEB_CYCLES(DEB_CYCLES)) u_ch_c (
    .i_clk   (clk),
    .i_rst_b (rst_b),
    .i_clr   (clr),
    .i_raw   (raw_c),
    .o_lvl   (c),
    .o_rise  (c_rise)
  );

endmodule

// File: doc/ex3_in_cond.md
Name: ex3_in_cond

Overview:
- Input-conditioning stage that sits directly upstream of the ex3 one-hot control FSM.
- It synchronises and debounces three raw asynchronous lines (switch or pin level) and drives them as the clean inputs a, b, c of the FSM.
- It also provides one-cycle rise pulses per channel for status and counters.
- There are three identical channels with independent debounce state.

Parameters:
- DEB_CYCLES, 4: consecutive synchronised samples needed to accept a new level. Legal range 2..255.
- CNT_W, $clog2(DEB_CYCLES): debounce counter width. Derived; do not override.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear. Has priority over all other activity except reset.
- raw_a  in  1  raw asynchronous input, channel a.
- raw_b  in  1  raw asynchronous input, channel b.
- raw_c  in  1  raw asynchronous input, channel c.
- a  out  1  debounced level, channel a. Feeds the FSM input a.
- b  out  1  debounced level, channel b. Feeds the FSM input b.
- c  out  1  debounced level, channel c. Feeds the FSM input c.
- a_rise  out  1  one-cycle pulse when a goes 0->1.
- b_rise  out  1  one-cycle pulse when b goes 0->1.
- c_rise  out  1  one-cycle pulse when c goes 0->1.

Behaviour:
- Reset (rst_b=0, asynchronous):
  - sync flops, counters, a/b/c and *_rise all go to 0.
  - Every channel FSM goes to ST0.
- Synchroniser: per channel, 2-flop chain raw_x -> s1_x -> s_x. Only s_x is seen by the channel FSM.
- Per-channel FSM, four states, one-hot encoded:
  - ST0 (stable 0, out=0):
    - s=1 -> CHK1 with cnt<=1.
    - else stay, cnt<=0.
  - CHK1 (candidate 1, out=0):
    - s=0 -> ST0, cnt<=0.
    - s=1 and cnt==DEB_CYCLES-1 -> ST1, out<=1, rise<=1, cnt<=0.
    - s=1 otherwise -> cnt<=cnt+1.
  - ST1 (stable 1, out=1):
    - s=0 -> CHK0 with cnt<=1.
    - else stay.
  - CHK0 (candidate 0, out=1):
    - s=1 -> ST1, cnt<=0.
    - s=0 and cnt==DEB_CYCLES-1 -> ST0, out<=0, cnt<=0.
    - s=0 otherwise -> cnt<=cnt+1.
- rise_x:
  - Registered; high for exactly the one cycle in which x first reads 1.
  - No pulse on the 1->0 transition.
- Latency:
  - A raw level held stable from before edge 1 appears on the output after rising edge DEB_CYCLES+2: 2 edges of sync, then DEB_CYCLES samples.
  - Default DEB_CYCLES=4 gives 6 edges.
- Glitch rejection:
  - Any s excursion shorter than DEB_CYCLES samples leaves the output unchanged, with no pulse.
  - The counter restarts from 0 on the next excursion; there is no accumulation across excursions.
- clr=1 at an edge:
  - All channels go to ST0, cnt=0, a/b/c=0, *_rise=0.
  - Sync flops keep sampling, so an input held high is re-accepted DEB_CYCLES samples after clr drops.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous outputs and pulses.
- Reset mid-debounce: no partial state survives; behaviour is identical to power-up.
- Outputs are driven from flops only. There is no combinational path from raw_* or clr to outputs.

Decomposition:
- Shared package ex3_pkg:
  - State index localparams ST0=0, CHK1=1, ST1=2, CHK0=3 and the state vector width.
  - Default DEB_CYCLES.
- Sub-module ex3_deb_ch: one channel containing sync, FSM, counter, level and rise outputs. Instantiated three times in ex3_in_cond.

Test Plan:
- Reset: rst_b low mid-cycle -> all outputs 0 immediately. Release, raw all 0 for 10 cycles -> outputs stay 0.
- Clean step: raw_a 0->1 before edge 1, DEB_CYCLES=4 -> a=1 and a_rise=1 after edge 6; a_rise=0 after edge 7; b=c=0 throughout.
- Glitch: raw_b high for 3 cycles then low -> b stays 0, b_rise never asserts. Repeat with 4 cycles high -> b=1 and one b_rise.
- Falling edge: a stable 1, raw_a 1->0 -> a=0 after edge 6, no pulse. A 2-cycle return to 1 during CHK0 -> a stays 1.
- Simultaneous/clr: raw_a, raw_b, raw_c rise together -> all three outputs and pulses on the same edge. clr pulse while all are 1 -> all 0 next edge; they re-assert 4 samples after clr drops.
- Async reset mid-CHK1 (cnt=2) -> state cleared. After release, raw held 1 -> output after a full 6 edges, not fewer.
